// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types, parity-mode constants, default 50 MHz / 115200 baud timing
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} rx_state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
  localparam int SYS_CLK_HZ  = 50_000_000;
  localparam int BAUD_DEF    = 115_200;
  localparam int OVS_DEF     = 16;
  localparam int CLK_DIV_DEF = SYS_CLK_HZ / (BAUD_DEF * OVS_DEF);
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-word valid/ready channel with per-word error flags and overrun pulse
interface uart_rx_core_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_perr;
  logic              rx_ferr;
  logic              rx_overrun;
  modport master (output rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun, input rx_ready);
  modport slave  (input rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun, output rx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divides clk by CLK_DIV into a one-cycle oversample tick; clr_i restarts the count
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = CLK_DIV > 1 ? clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt_q;
  assign tick_o = cnt_q == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i || tick_o) cnt_q <= '0;
    else cnt_q <= cnt_q + CW'(1);
endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with optional parity, framing/overrun flags and a one-word buffer.
// Define UART_RX_MAJORITY_EN to vote each sample over three consecutive ticks ending at the mid-bit tick.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int OVS       = OVS_DEF,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd_i,
  input  logic cfg_parity_en_i,
  input  logic cfg_parity_odd_i,
  output logic busy_o,
  uart_rx_core_if.master rx_if
);
  localparam int PW = clog2(OVS);
  localparam int BW = clog2(DATA_W + 1);
  localparam logic [PW-1:0] MID  = PW'(OVS / 2 - 1);
  localparam logic [PW-1:0] LAST = PW'(OVS - 1);
  rx_state_e         state_q;
  logic              rxd_m_q, rxd_s_q;
  logic [PW-1:0]     phase_q;
  logic [BW-1:0]     cnt_q;
  logic [DATA_W-1:0] shift_q, data_q;
  logic              par_en_q, par_odd_q, perr_q, ferr_q, done_q;
  logic              valid_q, out_perr_q, out_ferr_q, ovr_q;
  logic              tick, clr, samp, sample_d;
  always_ff @(posedge clk or posedge rst)
    if (rst) {rxd_m_q, rxd_s_q} <= 2'b11;
    else {rxd_m_q, rxd_s_q} <= {rxd_i, rxd_m_q};
  assign clr = state_q == S_IDLE && !rxd_s_q;
  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (.clk(clk), .rst(rst), .clr_i(clr), .tick_o(tick));
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rxd_s_q};
  assign sample_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_s_q) | (hist_q[0] & rxd_s_q);
`else
  assign sample_d = rxd_s_q;
`endif
  // START samples at its mid point; every later state samples one full bit after entry
  assign samp = tick && phase_q == (state_q == S_START ? MID : LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= PAR_EVEN;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (tick) phase_q <= phase_q == LAST ? '0 : phase_q + PW'(1);
      case (state_q)
        S_IDLE: if (!rxd_s_q) begin
          state_q   <= S_START;
          phase_q   <= '0;
          cnt_q     <= '0;
          par_en_q  <= cfg_parity_en_i;
          par_odd_q <= cfg_parity_odd_i;
          perr_q    <= 1'b0;
          ferr_q    <= 1'b0;
        end
        S_START: if (samp) begin
          state_q <= sample_d ? S_IDLE : S_DATA;
          phase_q <= '0;
        end
        S_DATA: if (samp) begin
          shift_q <= {sample_d, shift_q[DATA_W-1:1]};
          cnt_q   <= cnt_q + BW'(1);
          if (cnt_q == BW'(DATA_W - 1)) begin
            state_q <= par_en_q ? S_PARITY : S_STOP;
            phase_q <= '0;
            cnt_q   <= '0;
          end
        end
        S_PARITY: if (samp) begin
          perr_q  <= (^shift_q ^ sample_d) != par_odd_q;
          state_q <= S_STOP;
          phase_q <= '0;
        end
        S_STOP: if (samp) begin
          ferr_q <= ferr_q | ~sample_d;
          cnt_q  <= cnt_q + BW'(1);
          if (cnt_q == BW'(STOP_BITS - 1)) begin
            done_q  <= 1'b1;
            state_q <= rxd_s_q ? S_IDLE : S_BREAK;
            phase_q <= '0;
            cnt_q   <= '0;
          end
        end
        S_BREAK: if (rxd_s_q) begin
          state_q <= S_IDLE;
          phase_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  // An accept in the delivery cycle frees the buffer, so the new word loads instead of overrunning
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      out_perr_q <= 1'b0;
      out_ferr_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      ovr_q <= done_q && valid_q && !rx_if.rx_ready;
      if (done_q && (!valid_q || rx_if.rx_ready)) begin
        data_q     <= shift_q;
        out_perr_q <= perr_q;
        out_ferr_q <= ferr_q;
        valid_q    <= 1'b1;
      end else if (valid_q && rx_if.rx_ready) valid_q <= 1'b0;
    end
  assign busy_o           = state_q != S_IDLE;
  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_perr    = out_perr_q;
  assign rx_if.rx_ferr    = out_ferr_q;
  assign rx_if.rx_overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: randomized and directed frames on 8- and 9-bit receivers against a frame-level model
module tb_uart_rx_core;
  localparam int BIT = 64;
  logic clk = 1'b0, rst = 1'b1, rxd8 = 1'b1, rxd9 = 1'b1, par_en = 1'b0, par_odd = 1'b0, zero = 1'b0;
  logic busy8, busy9;
  int n_vec = 0, n_err = 0, cyc = 0, vcyc = 0, ovr = 0, busy_cyc = 0, rise_cyc = 0;
  logic [11:0] got[$];
  always #5 clk = ~clk;
  uart_rx_core_if #(.DATA_W(8)) if8();
  uart_rx_core_if #(.DATA_W(9)) if9();
  uart_rx_core #(.DATA_W(8), .CLK_DIV(4), .OVS(16), .STOP_BITS(1)) dut8 (
    .clk(clk), .rst(rst), .rxd_i(rxd8), .cfg_parity_en_i(par_en), .cfg_parity_odd_i(par_odd),
    .busy_o(busy8), .rx_if(if8));
  uart_rx_core #(.DATA_W(9), .CLK_DIV(4), .OVS(16), .STOP_BITS(1)) dut9 (
    .clk(clk), .rst(rst), .rxd_i(rxd9), .cfg_parity_en_i(zero), .cfg_parity_odd_i(zero),
    .busy_o(busy9), .rx_if(if9));
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (if8.rx_valid && if8.rx_ready) got.push_back({1'b0, if8.rx_perr, if8.rx_ferr, 1'b0, if8.rx_data});
    if (if9.rx_valid && if9.rx_ready) got.push_back({1'b1, if9.rx_perr, if9.rx_ferr, if9.rx_data});
    if (if8.rx_valid) begin
      vcyc++;
      if (rise_cyc == 0) rise_cyc = cyc;
    end
    if (if8.rx_overrun) ovr++;
    if (busy8) busy_cyc++;
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask
  function automatic logic exp_perr(input logic [8:0] d, input bit pon, input bit pb, input bit odd);
    return pon && ((($countones(d) + pb) % 2) != odd);
  endfunction
  task automatic drive(input bit nine, input bit v, input int n);
    if (nine) rxd9 = v;
    else rxd8 = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input bit nine, input int nb, input logic [8:0] d, input bit pon, input bit pb, input bit sb);
    drive(nine, 1'b0, BIT);
    for (int i = 0; i < nb; i++) drive(nine, d[i], BIT);
    if (pon) drive(nine, pb, BIT);
    drive(nine, sb, BIT);
  endtask
  task automatic expect_w(input string tag, input bit src, input logic [8:0] d, input bit pe, input bit fe);
    logic [11:0] w;
    chk({tag, "_count"}, got.size(), 1);
    if (got.size() != 0) begin
      w = got.pop_front();
      chk({tag, "_src"}, w[11], src);
      chk({tag, "_data"}, w[8:0], d);
      chk({tag, "_perr"}, w[10], pe);
      chk({tag, "_ferr"}, w[9], fe);
    end
    got.delete();
  endtask
  initial begin
    int c0;
    logic [8:0] d;
    bit pon, pb, sb;
    if8.rx_ready = 1'b1;
    if9.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_valid", if8.rx_valid, 0);
    chk("rst_data", if8.rx_data, 0);
    chk("rst_perr", if8.rx_perr, 0);
    chk("rst_ferr", if8.rx_ferr, 0);
    chk("rst_ovr", if8.rx_overrun, 0);
    rst = 1'b0;
    drive(0, 1'b1, BIT);
    c0 = cyc;
    vcyc = 0;
    rise_cyc = 0;
    send(0, 8, 9'h0A5, 0, 0, 1);
    expect_w("a5", 0, 9'h0A5, 0, 0);
    chk("a5_valid_cycles", vcyc, 1);
    chk("a5_latency_ok", (rise_cyc - c0 >= 606) && (rise_cyc - c0 <= 618), 1);
    drive(0, 1'b1, BIT);
    chk("a5_idle", busy8, 0);
    busy_cyc = 0;
    drive(0, 1'b0, 20);
    drive(0, 1'b1, 3 * BIT);
    chk("glitch_frames", got.size(), 0);
    chk("glitch_busy_window", busy_cyc > 0 && busy_cyc <= 40, 1);
    chk("glitch_idle", busy8, 0);
    got.delete();
    par_en = 1'b1;
    par_odd = 1'b0;
    send(0, 8, 9'h007, 1, 0, 1);
    expect_w("par_bad", 0, 9'h007, exp_perr(9'h007, 1, 0, 0), 0);
    drive(0, 1'b1, BIT);
    send(0, 8, 9'h007, 1, 1, 1);
    expect_w("par_good", 0, 9'h007, exp_perr(9'h007, 1, 1, 0), 0);
    drive(0, 1'b1, BIT);
    par_en = 1'b0;
    send(0, 8, 9'h0C3, 0, 0, 0);
    drive(0, 1'b0, 5 * BIT);
    expect_w("brk", 0, 9'h0C3, 0, 1);
    chk("brk_busy", busy8, 1);
    drive(0, 1'b1, 2 * BIT);
    chk("brk_frames", got.size(), 0);
    chk("brk_idle", busy8, 0);
    send(0, 8, 9'h096, 0, 0, 1);
    expect_w("post_brk", 0, 9'h096, 0, 0);
    drive(0, 1'b1, BIT);
    if8.rx_ready = 1'b0;
    ovr = 0;
    send(0, 8, 9'h011, 0, 0, 1);
    drive(0, 1'b1, BIT);
    send(0, 8, 9'h022, 0, 0, 1);
    drive(0, 1'b1, BIT);
    chk("ovr_valid", if8.rx_valid, 1);
    chk("ovr_data", if8.rx_data, 8'h11);
    chk("ovr_pulses", ovr, 1);
    chk("ovr_accepted", got.size(), 0);
    @(posedge clk);
    #1 if8.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    expect_w("ovr_drain", 0, 9'h011, 0, 0);
    chk("ovr_valid_clr", if8.rx_valid, 0);
    d = 9'h03C;
    drive(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(0, d[i], BIT);
    drive(0, d[4], BIT / 2);
    chk("mid_busy", busy8, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_data", if8.rx_data, 0);
    chk("mid_rst_valid", if8.rx_valid, 0);
    chk("mid_rst_flags", {if8.rx_perr, if8.rx_ferr, if8.rx_overrun}, 0);
    rxd8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b1, BIT);
    chk("mid_rst_frames", got.size(), 0);
    send(0, 8, 9'h05A, 0, 0, 1);
    expect_w("after_rst", 0, 9'h05A, 0, 0);
    drive(0, 1'b1, BIT);
    for (int k = 0; k < 24; k++) begin
      d = 9'($urandom_range(0, 255));
      pon = 1'($urandom);
      pb = 1'($urandom);
      sb = ($urandom % 4) != 0;
      par_en = pon;
      par_odd = 1'($urandom);
      send(0, 8, d, pon, pb, sb);
      expect_w($sformatf("rnd%0d", k), 0, d, exp_perr(d, pon, pb, par_odd), !sb);
      drive(0, 1'b1, sb ? $urandom_range(1, 2 * BIT) : BIT);
    end
    send(1, 9, 9'h1FF, 0, 0, 1);
    expect_w("w9_1ff", 1, 9'h1FF, 0, 0);
    drive(1, 1'b1, BIT);
    for (int k = 0; k < 4; k++) begin
      d = 9'($urandom_range(0, 511));
      sb = ($urandom % 3) != 0;
      send(1, 9, d, 0, 0, sb);
      expect_w($sformatf("w9_rnd%0d", k), 1, d, 0, !sb);
      drive(1, 1'b1, BIT);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
